// File: rtl/signed_integrate_dump.sv
// signed_integrate_dump
//   Integrate-and-dump stage for a signed sample stream. NSAMP accepted
//   samples are summed into an OWIDTH-bit signed accumulator; the frame
//   total is loaded into a held output register with a valid/ready
//   handshake, and the next frame starts on the same edge.
//
//   Build option: define SIGNED_INTEGRATE_DUMP_SATURATE_EN to clamp the
//   running sum to the OWIDTH signed range and report overflow on o_ovf.
//   Without it, the sum wraps in two's complement and o_ovf is always 0.
module signed_integrate_dump #(
  parameter int IWIDTH = 5,
  parameter int OWIDTH = 12,
  parameter int NSAMP  = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [IWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_clear,
  output logic [OWIDTH-1:0] o_data,
  output logic              o_ovf,
  output logic              o_valid,
  input  logic              i_ready
);

  localparam int              CW       = $clog2(NSAMP);
  localparam logic [CW-1:0]   CNT_LAST = CW'(NSAMP - 1);

  // Frame state
  logic signed [OWIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ovf_f_q, ovf_f_d;

  // Output register
  logic [OWIDTH-1:0]        out_data_q, out_data_d;
  logic                     out_ovf_q, out_ovf_d;
  logic                     out_valid_q, out_valid_d;

  // Datapath result for the current sample
  logic signed [OWIDTH-1:0] res;
  logic                     ovf_this;

  logic last_slot;
  logic accept;
  logic pop;

`ifdef SIGNED_INTEGRATE_DUMP_SATURATE_EN
  localparam logic signed [OWIDTH-1:0] SAT_MAX = {1'b0, {(OWIDTH-1){1'b1}}};
  localparam logic signed [OWIDTH-1:0] SAT_MIN = {1'b1, {(OWIDTH-1){1'b0}}};

  logic signed [OWIDTH:0] sum_w;

  // One guard bit: the add is out of range when the top two bits differ,
  // and the guard bit then tells which rail to clamp to.
  always_comb begin
    sum_w    = (OWIDTH+1)'(acc_q) + (OWIDTH+1)'($signed(i_data));
    ovf_this = sum_w[OWIDTH] ^ sum_w[OWIDTH-1];
    if (ovf_this) begin
      res = sum_w[OWIDTH] ? SAT_MIN : SAT_MAX;
    end else begin
      res = sum_w[OWIDTH-1:0];
    end
  end
`else
  // Truncating the wide sum to OWIDTH bits is the same as adding at
  // OWIDTH bits, so no guard bit is carried; overflow is never reported.
  always_comb begin
    res      = acc_q + OWIDTH'($signed(i_data));
    ovf_this = 1'b0;
  end
`endif

  // Only the frame-completing sample is held off by a pending result.
  assign last_slot = (cnt_q == CNT_LAST);
  assign o_ready   = !i_clear && !(last_slot && out_valid_q && !i_ready);
  assign accept    = i_valid && o_ready;
  assign pop       = out_valid_q && i_ready;

  // Next-state: accumulate, dump on the last slot, restart on clear.
  always_comb begin
    // NOTE: every variable driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_f_d     = ovf_f_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (pop) begin
      out_valid_d = 1'b0;
    end

    if (accept) begin
      if (last_slot) begin
        // A dump on the same edge as a pop reloads and keeps valid high.
        out_data_d  = res;
        out_ovf_d   = ovf_f_q | ovf_this;
        out_valid_d = 1'b1;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_f_d     = 1'b0;
      end else begin
        acc_d   = res;
        cnt_d   = cnt_q + 1'b1;
        ovf_f_d = ovf_f_q | ovf_this;
      end
    end

    // o_ready is low during clear, so no sample can be accepted here.
    if (i_clear) begin
      acc_d   = '0;
      cnt_d   = '0;
      ovf_f_d = 1'b0;
    end
  end

  // State registers with synchronous reset that overrides everything.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (i_reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_f_q     <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_f_q     <= ovf_f_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_data  = out_data_q;
  assign o_ovf   = out_ovf_q;
  assign o_valid = out_valid_q;

endmodule

// File: doc/signed_integrate_dump.md
# signed_integrate_dump

Integrate-and-dump stage that consumes the signed sum stream produced by the signed adder. It accumulates NSAMP accepted samples into a wider signed accumulator, then emits one result and restarts. It sits directly downstream of the adder in decimating DSP chains. It has valid/ready handshakes on both sides so that it can absorb backpressure from the next stage.

## Interface
Parameters:
- IWIDTH, 5, input sample width. This matches the adder output for 4-bit and 3-bit operands.
- OWIDTH, 12, accumulator and output width. Requires OWIDTH >= IWIDTH.
- NSAMP, 8, samples per dump. Requires NSAMP >= 2. The counter width is $clog2(NSAMP).

Ports (one clock; reset is synchronous and active-high):
- i_clk, in, 1, clock. All logic is on the rising edge.
- i_reset, in, 1, synchronous active-high reset.
- i_data, in, IWIDTH, signed input sample.
- i_valid, in, 1, i_data is valid.
- o_ready, out, 1, block can accept a sample this cycle.
- i_clear, in, 1, synchronous frame restart.
- o_data, out, OWIDTH, signed dump result.
- o_ovf, out, 1, the frame overflowed. Accompanies o_data.
- o_valid, out, 1, o_data/o_ovf valid.
- i_ready, in, 1, downstream accepts the result.

## Operation
- A sample is accepted when i_valid && o_ready is true at a rising edge.
- Internal state: accumulator acc[OWIDTH], counter cnt (0..NSAMP-1), sticky frame-overflow flag ovf_f.
- Sign extension: i_data is sign-extended to OWIDTH+1 bits. The sum is computed as nxt = acc + ext(i_data), in OWIDTH+1 bits.
- Accepted sample with cnt < NSAMP-1:
  - acc <= nxt, after saturation or wrap (see Configuration).
  - cnt increments.
  - ovf_f |= overflow of this add.
- Accepted sample with cnt == NSAMP-1 (dump):
  - o_data <= nxt, after saturation or wrap.
  - o_ovf <= ovf_f | overflow of this add.
  - o_valid <= 1.
  - acc, cnt and ovf_f are cleared on the same edge, so the next sample starts a fresh frame with no gap.
- Output register:
  - Holds o_data and o_ovf stable while o_valid && !i_ready.
  - o_valid falls on the edge where i_ready is high, unless a new dump loads on that same edge.
- o_ready is combinational: o_ready = !i_clear && !(cnt == NSAMP-1 && o_valid && !i_ready).
  - Only the frame-completing sample stalls. Samples for earlier positions in the frame keep being accepted while a result is pending.
- i_clear:
  - Clears acc, cnt and ovf_f.
  - A sample presented in the same cycle is not accepted, because o_ready is low.
  - A pending output is untouched.
- Reset:
  - acc, cnt, ovf_f, o_data, o_ovf and o_valid all go to 0, overriding everything, including mid-frame and with an output pending.
  - After reset, o_ready = 1.

## Timing
- Latency: o_valid is asserted on the edge that accepts the NSAMP-th sample, so it is visible in the following cycle.
- Throughput: one sample per cycle. With i_ready held high, one result every NSAMP cycles.
- Simultaneous pop and dump (o_valid && i_ready && final sample accepted): the new result loads and o_valid stays 1.
- Simultaneous i_clear and i_reset: reset wins. Both outcomes are identical for the internal state.
- Wrap boundary: the cnt transition NSAMP-1 -> 0 happens only on a dump, i_clear or i_reset.

## Configuration
- SIGNED_INTEGRATE_DUMP_SATURATE_EN:
  - Defined: any nxt outside [-2^(OWIDTH-1), 2^(OWIDTH-1)-1] is clamped to the nearest bound, and the overflow is recorded in ovf_f.
  - Undefined: nxt is truncated to OWIDTH bits (two's-complement wrap), and o_ovf is constant 0.

## Test plan
1. IWIDTH=5, OWIDTH=8, NSAMP=4, i_ready=1; after reset, samples 1,2,3,4 on consecutive cycles -> o_valid high for one cycle, o_data=10, o_ovf=0. Check the reset values of all outputs are 0 and o_ready=1.
2. Samples -16,-16,-16,-16 followed immediately by 1,1,1,1 -> o_data=-64, then o_data=4 exactly 4 cycles later. There must be no idle cycle between frames.
3. OWIDTH=6, samples 15,15,15,15:
   - With the macro: o_data=31 (partials 15, 30, then clamped to 31), o_ovf=1.
   - Without the macro: o_data=-4, o_ovf=0.
4. i_ready=0, two full frames of 1s:
   - First result (4) is held stable.
   - The second frame's 4th sample sees o_ready=0 until i_ready rises.
   - Then the second result 4 loads on the same edge as the pop, and o_valid stays 1.
5. Samples 5,5, then i_clear for one cycle with i_valid=1 and i_data=7 (not accepted), then 1,1,1,1 -> o_data=4.
6. i_reset after 3 samples of a frame with an output pending -> o_valid=0 and o_data=0 next cycle; then 2,2,2,2 -> o_data=8.
